// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit-queue state type, common to the TX queue
// and any future RX-side logic.
package uart_pkg;

    localparam int UART_OVERSAMPLE   = 16;
    localparam int UART_FRAME_BITS   = 10;
    localparam int UART_FRAME_CYCLES = UART_OVERSAMPLE * UART_FRAME_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } txq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter so full and empty never alias.
// Flush clears the contents synchronously and takes priority over push and pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Buffered byte source for uart_tx: queues bytes, issues one start pulse per byte,
// waits for done, and abandons a frame whose transmitter never reports done.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 200,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          flush,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_busy,
    input  logic          tx_done,
    output logic [LW-1:0] level,
    output logic          idle,
    output logic          timeout_err,
    output txq_state_t    state
);

    // Upstream port: a byte transfers on any rising edge where in_valid && in_ready;
    // in_ready depends on occupancy only, never on in_valid or the pop in progress.

    localparam int CW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;

    txq_state_t    state_q, state_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          pop;
    logic          push;
    logic [7:0]    fifo_head;
    logic [LW-1:0] fifo_level;
    logic          fifo_full;
    logic          fifo_empty;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .flush (flush),
        .head  (fifo_head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        wcnt_d      = wcnt_q;
        pop         = 1'b0;
        tx_start    = 1'b0;
        timeout_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !tx_busy && !flush) begin
                    pop       = 1'b1;
                    tx_data_d = fifo_head;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                tx_start = 1'b1;
                wcnt_d   = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                // A done arriving on the deadline cycle counts as success.
                if (tx_done) begin
                    state_d = IDLE;
                end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_err = 1'b1;
                    state_d     = IDLE;
                end else if (wcnt_q != '1) begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_data_q <= '0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            wcnt_q    <= wcnt_d;
        end
    end

    assign tx_data = tx_data_q;
    assign level   = fifo_level;
    assign idle    = (state_q == IDLE) && fifo_empty;
    assign state   = state_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a behavioural uart_tx stand-in that can
// also stall (hold busy) or hang (never signal done).
module tb_uart_tx_queue;
  import uart_pkg::*;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 200;
  localparam int LW      = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          flush;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          tx_done;
  logic [LW-1:0] level;
  logic          idle;
  logic          timeout_err;
  txq_state_t    state;

  uart_tx_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .flush       (flush),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .level       (level),
    .idle        (idle),
    .timeout_err (timeout_err),
    .state       (state)
  );

  // ---------------- transmitter model ----------------
  logic       m_busy;
  logic [7:0] m_cnt;
  logic [7:0] m_byte;
  logic [9:0] m_frame;
  logic       ser;
  logic       hold_busy = 1'b0;
  logic       hang_mode = 1'b0;
  logic       kill = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= '0;
      m_byte <= '0;
    end else if (kill) begin
      m_busy <= 1'b0;
    end else if (!m_busy && tx_start) begin
      m_busy <= 1'b1;
      m_cnt  <= '0;
      m_byte <= tx_data;
    end else if (m_busy) begin
      if (m_cnt == 8'(UART_FRAME_CYCLES - 1)) begin
        if (!hang_mode) m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 8'd1;
      end
    end
  end

  assign tx_done = m_busy && (m_cnt == 8'(UART_FRAME_CYCLES - 1)) && !hang_mode;
  assign tx_busy = m_busy || hold_busy;
  assign m_frame = {1'b1, m_byte, 1'b0};
  assign ser     = m_busy ? m_frame[m_cnt[7:4]] : 1'b1;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int start_cyc_q[$];
  int checks = 0;
  int errs = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int to_cnt = 0;
  int busy_viol = 0;
  int last_start = 0;
  int to_cyc = 0;
  int done_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        start_cnt++;
        last_start = cyc;
        start_cyc_q.push_back(cyc);
        if (tx_busy) busy_viol++;
        chk("sb_byte", {24'd0, tx_data}, (exp_q.size() > 0) ? {24'd0, exp_q.pop_front()} : 32'hDEAD);
      end
      if (tx_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (timeout_err) begin
        to_cnt++;
        to_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) chk("push_ready_wait", {31'd0, in_ready}, 1);
    in_valid = 1'b1;
    in_data  = b;
    exp_q.push_back(b);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    int n = 0;
    while (start_cnt < target && n < budget) begin
      step();
      n++;
    end
    chk(tag, (start_cnt >= target) ? 32'd1 : 32'd0, 1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!(idle && !tx_busy) && n < budget) begin
      step();
      n++;
    end
    chk(tag, {31'd0, idle}, 1);
  endtask

  // ---------------- test sequence ----------------
  logic [9:0] a5_bits;
  int t0;
  int base;
  int s;
  int d0;
  int to0;
  int n;

  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    a5_bits  = 10'b1101001010;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_tx_start", {31'd0, tx_start}, 0);
    chk("rst_tx_data", {24'd0, tx_data}, 0);
    chk("rst_level", {27'd0, level}, 0);
    chk("rst_idle", {31'd0, idle}, 1);
    chk("rst_timeout_err", {31'd0, timeout_err}, 0);
    chk("rst_state", {30'd0, state}, {30'd0, IDLE});
    rst_n = 1'b1;
    repeat (2) step();

    // single byte, exact frame timing and serial pattern
    push(8'hA5);
    t0 = cyc;
    chk("t1_level_after_push", {27'd0, level}, 1);
    wait_starts(1, 10, "t1_start_seen");
    chk("t1_start_latency", last_start - t0, 1);
    for (int i = 0; i < 10; i++) begin
      while (cyc < last_start + 1 + 16 * i + 8) step();
      chk("t1_serial_bit", {31'd0, ser}, {31'd0, a5_bits[i]});
    end
    while (cyc < t0 + 162) step();
    chk("t1_done_cycle", done_cyc, t0 + 161);
    chk("t1_idle", {31'd0, idle}, 1);
    chk("t1_level_empty", {27'd0, level}, 0);

    // fill to DEPTH while the transmitter is held busy
    hold_busy = 1'b1;
    base = start_cnt;
    start_cyc_q.delete();
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t2_level_full", {27'd0, level}, 16);
    chk("t2_in_ready_full", {31'd0, in_ready}, 0);
    in_valid = 1'b1;
    in_data  = 8'h10;
    step();
    chk("t2_push_refused", {27'd0, level}, 16);
    // release: pop while the held push waits, then the push lands
    hold_busy = 1'b0;
    step();
    step();
    exp_q.push_back(8'h10);
    in_valid = 1'b0;
    chk("t2_level_after_pop_push", {27'd0, level}, 16);
    wait_starts(base + 17, 17 * 162 + 50, "t2_all_started");
    for (int i = 1; i < 17; i++) begin
      if (i < start_cyc_q.size()) chk("t2_start_spacing", start_cyc_q[i] - start_cyc_q[i-1], 162);
    end
    wait_idle(300, "t2_drained");

    // flush while a frame is in flight with 5 queued
    base = start_cnt;
    push(8'h77);
    wait_starts(base + 1, 10, "t3_start_seen");
    repeat (10) step();
    chk("t3_state_wait", {30'd0, state}, {30'd0, WAIT});
    for (int i = 0; i < 5; i++) push(8'h80 + 8'(i));
    chk("t3_level_5", {27'd0, level}, 5);
    d0 = done_cnt;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk("t3_level_flushed", {27'd0, level}, 0);
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      step();
      n++;
    end
    chk("t3_frame_completed", done_cnt, d0 + 1);
    repeat (200) step();
    chk("t3_no_more_start", start_cnt, base + 1);

    // hung transmitter trips the watchdog
    hang_mode = 1'b1;
    base = start_cnt;
    to0  = to_cnt;
    push(8'h3C);
    push(8'hC3);
    wait_starts(base + 1, 20, "t4_start_seen");
    s = last_start;
    n = 0;
    while (to_cnt == to0 && n < 300) begin
      step();
      n++;
    end
    chk("t4_timeout_delay", to_cyc - s, TIMEOUT);
    chk("t4_state_idle", {30'd0, state}, {30'd0, IDLE});
    chk("t4_timeout_pulse_low", {31'd0, timeout_err}, 0);
    repeat (20) step();
    chk("t4_no_issue_while_busy", start_cnt, base + 1);
    chk("t4_timeout_once", to_cnt, to0 + 1);
    kill = 1'b1;
    step();
    kill = 1'b0;
    hang_mode = 1'b0;
    wait_starts(base + 2, 20, "t4_next_byte_issued");
    wait_idle(300, "t4_drained");

    // asynchronous reset mid-burst
    base = start_cnt;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    wait_starts(base + 1, 20, "t5_start_seen");
    repeat (20) step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_tx_start", {31'd0, tx_start}, 0);
    chk("t5_rst_tx_data", {24'd0, tx_data}, 0);
    chk("t5_rst_level", {27'd0, level}, 0);
    chk("t5_rst_in_ready", {31'd0, in_ready}, 1);
    chk("t5_rst_idle", {31'd0, idle}, 1);
    chk("t5_rst_timeout_err", {31'd0, timeout_err}, 0);
    chk("t5_rst_state", {30'd0, state}, {30'd0, IDLE});
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (300) step();
    chk("t5_no_start_after_reset", start_cnt, base + 1);
    push(8'h5A);
    wait_starts(base + 2, 10, "t5_new_push_issued");
    wait_idle(300, "t5_drained");

    chk("sb_all_bytes_sent", exp_q.size(), 0);
    chk("no_start_while_busy", busy_viol, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1, "time limit");
  end

endmodule
